alu_arb_ctrl: RTL

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_ctrl_pkg.sv | 34 +++
 rtl/alu_arb_ctrl_rr_arbiter2.sv | 19 +
 rtl/alu_arb_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/alu_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU arbitration controller.
package alu_arb_ctrl_pkg;

  // Controller sequencing: wait for a request, run it through the ALU, hold the response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit positions of the NZCV flags inside every 4-bit flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ALU control code; the ALU itself lives outside this block
  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 4'h0;
  localparam alu_ctrl_t ALU_SUB = 4'h1;
  localparam alu_ctrl_t ALU_AND = 4'h2;
  localparam alu_ctrl_t ALU_OR  = 4'h3;
  localparam alu_ctrl_t ALU_XOR = 4'h4;

  // One-hot requester vector for a single requester index
  function automatic logic [1:0] id_to_onehot(input logic id);
    logic [1:0] oh;
    oh     = 2'b00;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_arb_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is picked.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pure combinational pick; the caller owns and updates last_grant
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU, one operation at a time,
// and keeps the architectural NZCV flag register.
module alu_arb_ctrl
  import alu_arb_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ-1:0][N-1:0]    req_a_i,
  input  logic [NREQ-1:0][N-1:0]    req_b_i,
  input  logic [NREQ-1:0][3:0]      req_ctrl_i,
  input  logic [NREQ-1:0]           req_setflags_i,
  output logic [N-1:0]              alu_a_o,
  output logic [N-1:0]              alu_b_o,
  output alu_ctrl_t                 alu_control_o,
  input  logic [N-1:0]              alu_result_i,
  input  logic [3:0]                alu_flags_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  input  logic [NREQ-1:0]           rsp_ready_i,
  output logic [N-1:0]              rsp_result_o,
  output logic [3:0]                rsp_flags_o,
  output logic [3:0]                flags_o
);

  state_t     state_q;
  logic       last_grant_q;
  logic       id_q;
  logic       setflags_q;
  logic [1:0] grant;
  logic       grant_id;

  // The arbiter runs every cycle; its answer only matters while idle
  rr_arbiter2 u_arb (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign grant_id = grant[1];

  // Ready is a same-cycle handshake, so it is decoded from state rather than registered
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE) begin
      req_ready_o = grant;
    end
  end

  // Controller FSM: accept -> drive ALU -> capture result -> hold until consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      setflags_q    <= 1'b0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      alu_control_o <= '0;
      rsp_valid_o   <= '0;
      rsp_result_o  <= '0;
      rsp_flags_o   <= '0;
      flags_o       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            alu_a_o       <= req_a_i[grant_id];
            alu_b_o       <= req_b_i[grant_id];
            alu_control_o <= req_ctrl_i[grant_id];
            setflags_q    <= req_setflags_i[grant_id];
            id_q          <= grant_id;
            last_grant_q  <= grant_id;
            state_q       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_o <= alu_result_i;
          rsp_flags_o  <= alu_flags_i;
          rsp_valid_o  <= id_to_onehot(id_q);
          if (setflags_q) begin
            flags_o <= alu_flags_i;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i[id_q]) begin
            rsp_valid_o <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_o <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
